// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the data-memory side of the arbiter.
// The arbiter uses the slave view and requesters the master view; the memory
// model uses the memory view.
interface dmem_arbiter_if;
   logic        req0_valid;
   logic        req0_ready;
   logic        req0_we;
   logic [31:0] req0_addr;
   logic [31:0] req0_wdata;
   logic        rsp0_valid;
   logic [31:0] rsp0_rdata;
   logic        rsp0_err;

   logic        req1_valid;
   logic        req1_ready;
   logic        req1_we;
   logic [31:0] req1_addr;
   logic [31:0] req1_wdata;
   logic        rsp1_valid;
   logic [31:0] rsp1_rdata;
   logic        rsp1_err;

   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport slave (
      input  req0_valid, req0_we, req0_addr, req0_wdata,
      input  req1_valid, req1_we, req1_addr, req1_wdata,
      output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
      output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
      output mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output req0_valid, req0_we, req0_addr, req0_wdata,
      output req1_valid, req1_we, req1_addr, req1_wdata,
      input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
      input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err
   );

   modport memory (
      input  mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter with burst allowance in front of a single-port
// data memory; checks alignment/range and returns a registered response.
module dmem_arbiter #(
   parameter int DEPTH = 64,
   parameter int BURST = 2
) (
   input  logic          clk,
   input  logic          reset,
   dmem_arbiter_if.slave bus
);
   localparam logic [31:0] DEPTH_W = 32'(DEPTH);
   localparam logic [4:0]  BURST_W = 5'(BURST);

   logic [1:0]  valid;
   logic [1:0]  we;
   logic [1:0]  err;
   logic [1:0]  grant;
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];
   logic        sel;
   logic        prio_reg;
   logic [3:0]  burst_cnt_reg;

   assign valid    = {bus.req1_valid, bus.req0_valid};
   assign we       = {bus.req1_we, bus.req0_we};
   assign addr[0]  = bus.req0_addr;
   assign addr[1]  = bus.req1_addr;
   assign wdata[0] = bus.req0_wdata;
   assign wdata[1] = bus.req1_wdata;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_check
         assign err[gi] = (addr[gi][1:0] != 2'b00) ||
                          ({2'b00, addr[gi][31:2]} >= DEPTH_W);
      end
   endgenerate

   // Grant is suppressed while reset is high so no access leaks out.
   always_comb begin
      grant = 2'b00;
      if (!reset) begin
         if (&valid)
            grant = prio_reg ? 2'b10 : 2'b01;
         else
            grant = valid;
      end
   end

   assign sel            = grant[1];
   assign bus.req0_ready = grant[0];
   assign bus.req1_ready = grant[1];
   assign bus.mem_addr   = (|grant) ? addr[sel]  : 32'd0;
   assign bus.mem_wdata  = (|grant) ? wdata[sel] : 32'd0;
   assign bus.mem_we     = (|grant) && we[sel] && !err[sel];

   // Contested cycles consume burst allowance; uncontested grants hand
   // priority to the other port so it wins the next contest.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prio_reg      <= 1'b0;
         burst_cnt_reg <= 4'd0;
      end else if (&valid) begin
         if (sel == prio_reg && ({1'b0, burst_cnt_reg} + 5'd1) < BURST_W) begin
            burst_cnt_reg <= burst_cnt_reg + 4'd1;
         end else begin
            prio_reg      <= ~prio_reg;
            burst_cnt_reg <= 4'd0;
         end
      end else if (|grant) begin
         prio_reg      <= ~sel;
         burst_cnt_reg <= 4'd0;
      end
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
         logic        rsp_valid_reg;
         logic        rsp_err_reg;
         logic [31:0] rsp_rdata_reg;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               rsp_valid_reg <= 1'b0;
               rsp_err_reg   <= 1'b0;
               rsp_rdata_reg <= 32'd0;
            end else begin
               rsp_valid_reg <= grant[gi];
               rsp_err_reg   <= grant[gi] && err[gi];
               rsp_rdata_reg <= (grant[gi] && !we[gi] && !err[gi]) ? bus.mem_rdata : 32'd0;
            end
         end
      end
   endgenerate

   assign bus.rsp0_valid = g_rsp[0].rsp_valid_reg;
   assign bus.rsp0_err   = g_rsp[0].rsp_err_reg;
   assign bus.rsp0_rdata = g_rsp[0].rsp_rdata_reg;
   assign bus.rsp1_valid = g_rsp[1].rsp_valid_reg;
   assign bus.rsp1_err   = g_rsp[1].rsp_err_reg;
   assign bus.rsp1_rdata = g_rsp[1].rsp_rdata_reg;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (BURST=2 and BURST=1) see identical
// stimulus and are compared against a behavioural arbitration/memory model.
module tb_dmem_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;

   logic        req_valid [2];
   logic        req_we    [2];
   logic [31:0] req_addr  [2];
   logic [31:0] req_wdata [2];

   dmem_arbiter_if bus_a ();
   dmem_arbiter_if bus_b ();

   dmem_arbiter #(.DEPTH(64), .BURST(2)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
   dmem_arbiter #(.DEPTH(64), .BURST(1)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

   assign bus_a.req0_valid = req_valid[0];
   assign bus_a.req0_we    = req_we[0];
   assign bus_a.req0_addr  = req_addr[0];
   assign bus_a.req0_wdata = req_wdata[0];
   assign bus_a.req1_valid = req_valid[1];
   assign bus_a.req1_we    = req_we[1];
   assign bus_a.req1_addr  = req_addr[1];
   assign bus_a.req1_wdata = req_wdata[1];
   assign bus_b.req0_valid = req_valid[0];
   assign bus_b.req0_we    = req_we[0];
   assign bus_b.req0_addr  = req_addr[0];
   assign bus_b.req0_wdata = req_wdata[0];
   assign bus_b.req1_valid = req_valid[1];
   assign bus_b.req1_we    = req_we[1];
   assign bus_b.req1_addr  = req_addr[1];
   assign bus_b.req1_wdata = req_wdata[1];

   // Memory contents are a fixed pattern, reloaded while reset is high.
   function automatic logic [31:0] fill(input int i);
      return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A5A5A;
   endfunction

   logic [31:0] mem_a [64];
   logic [31:0] mem_b [64];
   assign bus_a.mem_rdata = mem_a[bus_a.mem_addr[7:2]];
   assign bus_b.mem_rdata = mem_b[bus_b.mem_addr[7:2]];
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 64; i++) begin
            mem_a[i] <= fill(i);
            mem_b[i] <= fill(i);
         end
      end else begin
         if (bus_a.mem_we) mem_a[bus_a.mem_addr[7:2]] <= bus_a.mem_wdata;
         if (bus_b.mem_we) mem_b[bus_b.mem_addr[7:2]] <= bus_b.mem_wdata;
      end
   end

   // Observed outputs, indexed [instance][port].
   logic        ob_ready [2][2];
   logic        ob_rv    [2][2];
   logic        ob_err   [2][2];
   logic [31:0] ob_rdata [2][2];
   logic        ob_we    [2];
   logic [31:0] ob_addr  [2];
   logic [31:0] ob_wdata [2];
   assign ob_ready[0][0] = bus_a.req0_ready;
   assign ob_ready[0][1] = bus_a.req1_ready;
   assign ob_ready[1][0] = bus_b.req0_ready;
   assign ob_ready[1][1] = bus_b.req1_ready;
   assign ob_rv[0][0]    = bus_a.rsp0_valid;
   assign ob_rv[0][1]    = bus_a.rsp1_valid;
   assign ob_rv[1][0]    = bus_b.rsp0_valid;
   assign ob_rv[1][1]    = bus_b.rsp1_valid;
   assign ob_err[0][0]   = bus_a.rsp0_err;
   assign ob_err[0][1]   = bus_a.rsp1_err;
   assign ob_err[1][0]   = bus_b.rsp0_err;
   assign ob_err[1][1]   = bus_b.rsp1_err;
   assign ob_rdata[0][0] = bus_a.rsp0_rdata;
   assign ob_rdata[0][1] = bus_a.rsp1_rdata;
   assign ob_rdata[1][0] = bus_b.rsp0_rdata;
   assign ob_rdata[1][1] = bus_b.rsp1_rdata;
   assign ob_we[0]       = bus_a.mem_we;
   assign ob_we[1]       = bus_b.mem_we;
   assign ob_addr[0]     = bus_a.mem_addr;
   assign ob_addr[1]     = bus_b.mem_addr;
   assign ob_wdata[0]    = bus_a.mem_wdata;
   assign ob_wdata[1]    = bus_b.mem_wdata;

   // ---------------- reference model ----------------
   int          m_prio  [2];
   int          m_cnt   [2];
   int          m_burst [2] = '{2, 1};
   logic [31:0] ref_mem [2][64];
   logic        e_valid [2][2];
   logic        e_err   [2][2];
   logic [31:0] e_rdata [2][2];

   function automatic bit faulty(input int p);
      return (req_addr[p][1:0] != 2'b00) || (req_addr[p] >= 32'd256);
   endfunction

   function automatic int pick(input int k);
      if (reset) return -1;
      if (req_valid[0] && req_valid[1]) return m_prio[k];
      if (req_valid[0]) return 0;
      if (req_valid[1]) return 1;
      return -1;
   endfunction

   always @(posedge clk or posedge reset) begin
      for (int k = 0; k < 2; k++) begin
         int g;
         g = pick(k);
         for (int p = 0; p < 2; p++) begin
            e_valid[k][p] = 1'b0;
            e_err[k][p]   = 1'b0;
            e_rdata[k][p] = 32'd0;
         end
         if (reset) begin
            m_prio[k] = 0;
            m_cnt[k]  = 0;
            for (int i = 0; i < 64; i++) ref_mem[k][i] = fill(i);
         end else if (g >= 0) begin
            e_valid[k][g] = 1'b1;
            e_err[k][g]   = faulty(g);
            if (!faulty(g)) begin
               if (req_we[g]) ref_mem[k][req_addr[g][7:2]] = req_wdata[g];
               else           e_rdata[k][g] = ref_mem[k][req_addr[g][7:2]];
            end
            if (req_valid[0] && req_valid[1]) begin
               if (g == m_prio[k] && m_cnt[k] + 1 < m_burst[k]) begin
                  m_cnt[k]++;
               end else begin
                  m_prio[k] = 1 - m_prio[k];
                  m_cnt[k]  = 0;
               end
            end else begin
               m_prio[k] = 1 - g;
               m_cnt[k]  = 0;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic v0, input logic we0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic v1, input logic we1, input logic [31:0] a1, input logic [31:0] d1);
      req_valid[0] = v0; req_we[0] = we0; req_addr[0] = a0; req_wdata[0] = d0;
      req_valid[1] = v1; req_we[1] = we1; req_addr[1] = a1; req_wdata[1] = d1;
   endtask

   task automatic do_reset;
      @(posedge clk); #1;
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      reset = 1'b1;
      drive(1, 0, 32'h0, 32'h0, 1, 1, 32'h4, 32'h7);
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         tests_run++;
         if ({ob_ready[k][1], ob_ready[k][0], ob_we[k], ob_rv[k][1], ob_rv[k][0],
              ob_err[k][1], ob_err[k][0]} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_ctl k=%0d got rdy=%b%b we=%b rv=%b%b err=%b%b want all 0", k,
                     ob_ready[k][1], ob_ready[k][0], ob_we[k], ob_rv[k][1], ob_rv[k][0],
                     ob_err[k][1], ob_err[k][0]);
         end
         tests_run++;
         if (ob_rdata[k][0] !== 32'd0 || ob_rdata[k][1] !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_rdata k=%0d got %h/%h want 0", k, ob_rdata[k][0], ob_rdata[k][1]);
         end
      end
      $display("[TB] reset: outputs idle while reset high");
      @(posedge clk); #1;
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_store_load;
      logic [31:0] want_rd [4] = '{32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
      logic        want_rv [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      for (int s = 0; s < 4; s++) begin
         @(posedge clk); #1;
         if (s == 0)      drive(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
         else if (s == 1) drive(1, 0, 32'h10, 32'h0, 0, 0, 0, 0);
         else             drive(0, 0, 0, 0, 0, 0, 0, 0);
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (ob_rv[k][0] !== want_rv[s] || ob_err[k][0] !== 1'b0 || ob_rdata[k][0] !== want_rd[s]) begin
               tests_failed++;
               $display("FAIL store_load_rsp k=%0d step=%0d got v=%b e=%b d=%h want v=%b e=0 d=%h",
                        k, s, ob_rv[k][0], ob_err[k][0], ob_rdata[k][0], want_rv[s], want_rd[s]);
            end
            if (s == 0) begin
               tests_run++;
               if (ob_ready[k][0] !== 1'b1 || ob_we[k] !== 1'b1 || ob_addr[k] !== 32'h10 ||
                   ob_wdata[k] !== 32'hDEADBEEF) begin
                  tests_failed++;
                  $display("FAIL store_drive k=%0d got rdy=%b we=%b a=%h d=%h want 1 1 10 deadbeef",
                           k, ob_ready[k][0], ob_we[k], ob_addr[k], ob_wdata[k]);
               end
            end
         end
         $display("[TB] store_load step %0d rsp0_valid=%b rsp0_rdata=%h", s, ob_rv[0][0], ob_rdata[0][0]);
      end
   endtask

   localparam int SEQ [2][6] = '{'{0, 0, 1, 1, 0, 0}, '{0, 1, 0, 1, 0, 1}};

   task automatic test_contested;
      do_reset();
      for (int c = 0; c < 7; c++) begin
         @(posedge clk); #1;
         if (c < 6) drive(1, 0, $urandom_range(0, 63) << 2, 0, 1, 0, $urandom_range(0, 63) << 2, 0);
         else       drive(0, 0, 0, 0, 0, 0, 0, 0);
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (c < 6) begin
               tests_run++;
               if ({ob_ready[k][1], ob_ready[k][0], ob_we[k]} !== (SEQ[k][c] == 1 ? 3'b100 : 3'b010)) begin
                  tests_failed++;
                  $display("FAIL contested_grant k=%0d cyc=%0d got rdy=%b%b we=%b want port %0d, we=0",
                           k, c, ob_ready[k][1], ob_ready[k][0], ob_we[k], SEQ[k][c]);
               end
            end
            if (c > 0) begin
               tests_run++;
               if ({ob_rv[k][1], ob_rv[k][0]} !== (SEQ[k][c-1] == 1 ? 2'b10 : 2'b01) ||
                   ob_rdata[k][SEQ[k][c-1]] !== e_rdata[k][SEQ[k][c-1]]) begin
                  tests_failed++;
                  $display("FAIL contested_rsp k=%0d cyc=%0d got rv=%b%b d=%h want port %0d d=%h",
                           k, c, ob_rv[k][1], ob_rv[k][0], ob_rdata[k][SEQ[k][c-1]],
                           SEQ[k][c-1], e_rdata[k][SEQ[k][c-1]]);
               end
            end
         end
         $display("[TB] contested cyc %0d grant_a=%b%b grant_b=%b%b", c,
                  ob_ready[0][1], ob_ready[0][0], ob_ready[1][1], ob_ready[1][0]);
      end
   endtask

   task automatic test_fault;
      logic [31:0] addrs [3] = '{32'h102, 32'h100, 32'h0};
      do_reset();
      for (int s = 0; s < 4; s++) begin
         @(posedge clk); #1;
         if (s < 2)       drive(0, 0, 0, 0, 1, 1, addrs[s], 32'hCAFE0000 + 32'(s));
         else if (s == 2) drive(0, 0, 0, 0, 1, 0, addrs[s], 0);
         else             drive(0, 0, 0, 0, 0, 0, 0, 0);
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (s < 3) begin
               tests_run++;
               if (ob_ready[k][1] !== 1'b1 || ob_we[k] !== 1'b0) begin
                  tests_failed++;
                  $display("FAIL fault_drive k=%0d step=%0d got rdy1=%b we=%b want 1 0",
                           k, s, ob_ready[k][1], ob_we[k]);
               end
            end
            if (s == 1 || s == 2) begin
               tests_run++;
               if (ob_rv[k][1] !== 1'b1 || ob_err[k][1] !== 1'b1 || ob_rdata[k][1] !== 32'd0) begin
                  tests_failed++;
                  $display("FAIL fault_rsp k=%0d step=%0d got v=%b e=%b d=%h want 1 1 0",
                           k, s, ob_rv[k][1], ob_err[k][1], ob_rdata[k][1]);
               end
            end
            if (s == 3) begin
               tests_run++;
               if (ob_rv[k][1] !== 1'b1 || ob_err[k][1] !== 1'b0 || ob_rdata[k][1] !== fill(0)) begin
                  tests_failed++;
                  $display("FAIL fault_word0 k=%0d got v=%b e=%b d=%h want 1 0 %h",
                           k, ob_rv[k][1], ob_err[k][1], ob_rdata[k][1], fill(0));
               end
            end
         end
         $display("[TB] fault step %0d rsp1 v=%b err=%b rdata=%h", s, ob_rv[0][1], ob_err[0][1], ob_rdata[0][1]);
      end
   endtask

   task automatic test_reset_mid;
      do_reset();
      for (int s = 0; s < 2; s++) begin
         @(posedge clk); #1;
         drive(1, 0, 32'h20 + 32'(4 * s), 0, 0, 0, 0, 0);
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (ob_ready[k][0] !== 1'b1 || ob_rv[k][0] !== (s == 1)) begin
               tests_failed++;
               $display("FAIL midrst_pre k=%0d step=%0d got rdy0=%b rv0=%b want 1 %0d",
                        k, s, ob_ready[k][0], ob_rv[k][0], s);
            end
         end
      end
      reset = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         tests_run++;
         if (ob_rv[k][0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_async k=%0d got rv0=%b want 0", k, ob_rv[k][0]);
         end
      end
      @(posedge clk); #1;
      drive(1, 0, 32'h8, 0, 1, 0, 32'hC, 0);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         tests_run++;
         if ({ob_rv[k][0], ob_ready[k][1], ob_ready[k][0], ob_we[k]} !== 4'b0) begin
            tests_failed++;
            $display("FAIL midrst_hold k=%0d got rv0=%b rdy=%b%b we=%b want 0", k,
                     ob_rv[k][0], ob_ready[k][1], ob_ready[k][0], ob_we[k]);
         end
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         tests_run++;
         if ({ob_ready[k][1], ob_ready[k][0]} !== 2'b01) begin
            tests_failed++;
            $display("FAIL midrst_prio k=%0d got rdy=%b%b want 01", k, ob_ready[k][1], ob_ready[k][0]);
         end
      end
      $display("[TB] reset_mid: response discarded, port 0 first after release");
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_uncontested;
      logic [1:0] want [3] = '{2'b10, 2'b01, 2'b10};
      do_reset();
      for (int s = 0; s < 3; s++) begin
         @(posedge clk); #1;
         drive(s != 0, 0, 32'h4, 0, s != 1, 0, 32'h8, 0);
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            tests_run++;
            if ({ob_ready[k][1], ob_ready[k][0]} !== want[s]) begin
               tests_failed++;
               $display("FAIL uncontested k=%0d step=%0d got rdy=%b%b want %b",
                        k, s, ob_ready[k][1], ob_ready[k][0], want[s]);
            end
         end
         $display("[TB] uncontested step %0d grant=%b%b", s, ob_ready[0][1], ob_ready[0][0]);
      end
   endtask

   function automatic logic [31:0] rnd_addr();
      int r;
      r = $urandom_range(0, 15);
      if (r < 11)      return 32'($urandom_range(0, 7)) << 2;
      else if (r < 13) return 32'($urandom_range(60, 70)) << 2;
      else             return (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(1, 3));
   endfunction

   task automatic test_back_to_back;
      do_reset();
      for (int c = 0; c < 200; c++) begin
         @(posedge clk); #1;
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rnd_addr(), $urandom,
               $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rnd_addr(), $urandom);
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            int          g;
            logic        x_we;
            logic [31:0] x_addr;
            g = pick(k);
            x_we = 1'b0;
            x_addr = 32'd0;
            if (g >= 0) begin
               x_we = req_we[g] && !faulty(g);
               x_addr = req_addr[g];
            end
            tests_run++;
            if ({ob_ready[k][1], ob_ready[k][0], ob_we[k], ob_rv[k][1], ob_rv[k][0], ob_err[k][1], ob_err[k][0]} !==
                {g == 1, g == 0, x_we, e_valid[k][1], e_valid[k][0], e_err[k][1], e_err[k][0]}) begin
               tests_failed++;
               $display("FAIL rnd_ctl k=%0d cyc=%0d got rdy=%b%b we=%b rv=%b%b err=%b%b want grant=%0d we=%b rv=%b%b err=%b%b",
                        k, c, ob_ready[k][1], ob_ready[k][0], ob_we[k], ob_rv[k][1], ob_rv[k][0],
                        ob_err[k][1], ob_err[k][0], g, x_we, e_valid[k][1], e_valid[k][0],
                        e_err[k][1], e_err[k][0]);
            end
            tests_run++;
            if (ob_addr[k] !== x_addr || (x_we && ob_wdata[k] !== req_wdata[g])) begin
               tests_failed++;
               $display("FAIL rnd_mem k=%0d cyc=%0d got a=%h d=%h want a=%h", k, c, ob_addr[k], ob_wdata[k], x_addr);
            end
            tests_run++;
            if (ob_rdata[k][0] !== e_rdata[k][0] || ob_rdata[k][1] !== e_rdata[k][1]) begin
               tests_failed++;
               $display("FAIL rnd_rdata k=%0d cyc=%0d got %h/%h want %h/%h", k, c,
                        ob_rdata[k][0], ob_rdata[k][1], e_rdata[k][0], e_rdata[k][1]);
            end
         end
         if (pick(0) >= 0)
            $display("[TB] rnd cyc %0d port %0d we=%b addr=%h", c, pick(0), req_we[pick(0)], req_addr[pick(0)]);
      end
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      test_reset();
      test_store_load();
      test_contested();
      test_fault();
      test_reset_mid();
      test_uncontested();
      test_back_to_back();
      @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (64 x 32-bit words, combinational read, write on clock edge) between two requesters: port 0 (CPU load/store) and port 1 (DMA/debug loader).
- Arbitrates at most one access per cycle using round-robin with a configurable burst allowance.
- Checks alignment and range, and returns a registered response one cycle after acceptance.
- Sits between the requesters and the data memory.

Parameters:
- DEPTH, 64, number of 32-bit words in the memory; word index addr[31:2] must be < DEPTH.
- BURST, 2, maximum consecutive contested grants a port may win before priority flips (legal range 1..15).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  port 0 request present.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_we  in  1  1 = store, 0 = load.
- req0_addr  in  32  byte address.
- req0_wdata  in  32  store data.
- rsp0_valid  out  1  port 0 response valid (one-cycle pulse).
- rsp0_rdata  out  32  load data; 0 for stores and errors.
- rsp0_err  out  1  access faulted.
- req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata, rsp1_err: same as port 0, for port 1.
- mem_we  out  1  memory write_enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data (combinational from mem_addr).

Behaviour:
- Reset values: all rsp*_valid, rsp*_err, rsp*_rdata = 0; prio = port 0; burst_cnt = 0.
- While reset is high: req*_ready = 0 and mem_we = 0.
- Grant is combinational, at most one port per cycle:
  - Only one port valid: grant that port.
  - Both valid: grant the port indicated by prio.
  - Neither valid: no grant; mem_addr = 0, mem_we = 0.
- reqN_ready = grantN. Acceptance = reqN_valid && reqN_ready.
- Fault: err = (addr[1:0] != 0) || (addr[31:2] >= DEPTH).
- Memory drive for the granted port:
  - mem_addr = that port's addr.
  - mem_wdata = that port's wdata.
  - mem_we = we && !err. A faulting store never writes memory.
- Response, registered and issued exactly 1 cycle after acceptance:
  - rspN_valid = 1 for one cycle.
  - rspN_err = err.
  - rspN_rdata = mem_rdata captured at acceptance if load && !err, else 0.
- On cycles with no response for a port: rspN_valid = 0 and rdata/err return to 0.
- Responses are in order; there is no backpressure on responses, so requesters must accept them.
- Burst/priority update, contested cycles only (both valid):
  - If the winner == prio and burst_cnt + 1 < BURST: burst_cnt increments and prio holds.
  - Otherwise prio flips to the other port and burst_cnt = 0.
- Uncontested grant: burst_cnt = 0, prio = the other port from the one just granted.
- Idle cycle: prio and burst_cnt hold.
- With BURST = 1 and both ports continuously valid, grants strictly alternate.
- Back-to-back: a new acceptance is allowed every cycle, including a load to the address stored the previous cycle. That load returns the new data because the write has committed at the edge.
- Requests may change or drop while not ready. No request state is held internally.
- Reset asserted mid-stream: any pending response is discarded (rsp*_valid forced to 0 immediately); arbitration restarts with prio = port 0.

Test Plan:
- Port 0 stores 0xDEADBEEF to 0x10, then loads 0x10 next cycle → store response: rsp0_valid=1, err=0, rdata=0. Load response: rsp0_rdata=0xDEADBEEF, 1 cycle after acceptance.
- Both ports continuously request loads, BURST=2, from reset → grant sequence 0,0,1,1,0,0; each rsp pulse lands 1 cycle after its ready.
- BURST=1, both valid for 4 cycles → grants 0,1,0,1; mem_we never asserts for loads.
- Port 1 stores to 0x102 (misaligned), then to 0x100 (index 64 >= DEPTH) → mem_we=0 both cycles; rsp1_err=1, rdata=0; a load of word 0 afterwards is unchanged.
- Port 0 load accepted, reset asserted before the next edge → rsp0_valid stays 0. After release, with both valid, port 0 is granted first.
- Port 1 alone, then port 0 alone, then both valid → uncontested grants set prio opposite to the last granted port, so the contested cycle grants port 1.
